// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler and related shared-resource blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LOW,
    WAIT_HIGH,
    DONE
  } arb_state_t;

  localparam int BAUD_DIV   = 2604;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Request/transmitter bundle of the UART scheduler; master is the client/transmitter side.
interface uart_tx_arb_if #(
  parameter int NUM_REQ   = 4,
  parameter int MSG_BYTES = 3
);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*8*MSG_BYTES-1:0] msg;
  logic                           tx_rdy;
  logic                           tx_start;
  logic [7:0]                     tx_data;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             done;
  logic                           busy;

  modport master (
    output req, msg, tx_rdy,
    input  tx_start, tx_data, grant, done, busy
  );

  modport slave (
    input  req, msg, tx_rdy,
    output tx_start, tx_data, grant, done, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request after the previous winner, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_lastGrant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  logic [IW-1:0] w_pos;

  // Offset NUM_REQ lands back on the previous winner, so a lone requester can win repeatedly.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_pos = IW'((int'(i_lastGrant) + k) % NUM_REQ);
      if (!o_valid && i_req[w_pos]) begin
        o_valid        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one 8N1 UART transmitter among NUM_REQ requesters, sending each
// captured MSG_BYTES message MSB byte first and pulsing done to its owner.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MSG_BYTES = 3
) (
  input logic         clk,
  input logic         rst_n,
  uart_tx_arb_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MSG_BYTES + 1);
  localparam int MW = 8 * MSG_BYTES;

  arb_state_t         r_state;
  arb_state_t         w_nextState;
  logic [IW-1:0]      r_lastGrant;
  logic [NUM_REQ-1:0] r_grant;
  logic [MW-1:0]      r_shift;
  logic [CW-1:0]      r_cnt;

  logic [NUM_REQ-1:0] w_pickGrant;
  logic [IW-1:0]      w_pickIdx;
  logic               w_pickValid;
  logic [MW-1:0]      w_winMsg;
  logic               w_lastByte;
  logic               w_load;
  logic               w_advance;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .i_req      (bus.req),
    .i_lastGrant(r_lastGrant),
    .o_grant    (w_pickGrant),
    .o_idx      (w_pickIdx),
    .o_valid    (w_pickValid)
  );

  always_comb begin
    w_winMsg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pickIdx == IW'(i)) begin
        w_winMsg = bus.msg[i*MW +: MW];
      end
    end
  end

  assign w_lastByte = (r_cnt == CW'(MSG_BYTES - 1));

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (w_pickValid && bus.tx_rdy) w_nextState = START;
      START:     w_nextState = WAIT_LOW;
      WAIT_LOW:  if (!bus.tx_rdy) w_nextState = WAIT_HIGH;
      WAIT_HIGH: if (bus.tx_rdy) w_nextState = w_lastByte ? DONE : START;
      DONE:      w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  assign w_load    = (r_state == IDLE) && (w_nextState == START);
  assign w_advance = (r_state == WAIT_HIGH) && (w_nextState == START);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // The winner's message is frozen at grant time; later msg changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastGrant <= IW'(NUM_REQ - 1);
      r_grant     <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
    end else if (w_load) begin
      r_lastGrant <= w_pickIdx;
      r_grant     <= w_pickGrant;
      r_shift     <= w_winMsg;
      r_cnt       <= '0;
    end else if (w_advance) begin
      r_shift <= r_shift << 8;
      r_cnt   <= r_cnt + CW'(1);
    end else if (r_state == DONE) begin
      r_grant <= '0;
    end
  end

  assign bus.tx_start = (r_state == START);
  assign bus.tx_data  = r_shift[MW-1 -: 8];
  assign bus.grant    = r_grant;
  assign bus.done     = (r_state == DONE) ? r_grant : '0;
  assign bus.busy     = (r_state != IDLE);

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin scheduler that shares the single 8N1 UART transmitter (19200 baud, 2604-clock bit period) among several requesters, each sending a fixed-length multi-byte message. It sits between client logic and the transmitter. It serializes each message MSB-byte-first into transmitter `tx_start`/`tx_data` pulses, paced by the transmitter's `tx_rdy`. It returns a one-cycle `done` to the requester whose message went out.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `MSG_BYTES`, 3: bytes per message, legal range 1..4.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  NUM_REQ: per-requester request level, held high until that requester's `done`.
- `msg`  in  NUM_REQ*8*MSG_BYTES: flattened messages; requester i owns slice [i*8*MSG_BYTES +: 8*MSG_BYTES].
- `tx_rdy`  in  1: transmitter idle flag.
- `tx_start`  out  1: one-cycle start pulse to the transmitter.
- `tx_data`  out  8: byte to the transmitter; valid while `tx_start` is high.
- `grant`  out  NUM_REQ: one-hot owner of the current message; all zero when idle.
- `done`  out  NUM_REQ: one-cycle pulse on the owner's bit after its last byte completes.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: no message in progress.
  - START: `tx_start`=1 for exactly one cycle.
  - WAIT_LOW: wait for `tx_rdy`=0, confirming the transmitter accepted the byte.
  - WAIT_HIGH: wait for `tx_rdy`=1, meaning the frame is finished.
  - DONE: `done[owner]`=1 for one cycle.
- Transitions:
  - IDLE→START when any `req` bit is high and `tx_rdy`=1.
  - START→WAIT_LOW unconditionally.
  - WAIT_LOW→WAIT_HIGH on `tx_rdy`=0.
  - WAIT_HIGH→START on `tx_rdy`=1 if bytes remain.
  - WAIT_HIGH→DONE on `tx_rdy`=1 if the last byte just finished.
  - DONE→IDLE unconditionally.
- Arbitration on IDLE→START:
  - Pick the first requester with `req` high, scanning from last_grant+1 upward and wrapping modulo NUM_REQ.
  - last_grant resets to NUM_REQ-1, so requester 0 wins first.
  - Register `grant` one-hot and update last_grant to the winner.
- Message capture: on the grant edge, the winner's message is copied into an internal 8*MSG_BYTES shift register. Changes to `msg` after the grant have no effect.
- Byte order and counter:
  - `tx_data` = shift register [top byte].
  - Each WAIT_HIGH→START shifts the register left by 8 and increments the byte counter.
  - The byte counter is $clog2(MSG_BYTES+1) bits wide. The last byte is the one where counter == MSG_BYTES-1.
- Requester contract: the requester deasserts `req` at the clock edge where it samples `done` high. A `req` still high in the following IDLE cycle is treated as a new message.
- `req` changes on non-owners during a transaction are ignored until IDLE. A non-owner's `req` dropping before it is granted is permitted; no `done` is issued to it.
- The block never asserts `tx_start` while `tx_rdy`=0 in IDLE.
- WAIT_LOW has no timeout; the transmitter guarantees `tx_rdy` falls one cycle after `tx_start`.

## Timing
- Reset values: `tx_start`=0, `tx_data`=8'h00, `grant`=0, `done`=0, `busy`=0. State is IDLE, last_grant=NUM_REQ-1, and the byte counter and shift register are 0.
- All outputs are registered or decoded directly from the state register, with no input-to-output combinational path.
- Start latency: with `req` high in cycle 0 (IDLE, `tx_rdy`=1), `grant`, `busy` and `tx_start` go high in cycle 1.
- Byte pacing: the next `tx_start` comes exactly 1 cycle after the first cycle `tx_rdy` is sampled high in WAIT_HIGH.
- Done timing: `done` is high the cycle after the last `tx_rdy` rise is sampled. `grant` and `busy` fall with the DONE→IDLE transition.
- Back-to-back messages: the earliest next grant is the cycle after DONE, giving a 1-cycle IDLE gap.
- Reset mid-message: the block returns to reset values immediately, the message is discarded, and no `done` is issued. A partial byte on the line is the transmitter's concern.

## Structure
- Shared package `uart_pkg`:
  - arbiter state enum `arb_state_t` {IDLE, START, WAIT_LOW, WAIT_HIGH, DONE};
  - `BAUD_DIV` = 2604;
  - `FRAME_BITS` = 10.
- Sub-module `rr_pick`: purely combinational. Takes `req` and last_grant and returns a one-hot winner plus a valid flag, and is parameterized by NUM_REQ. It is reused by other shared-resource blocks.
- The top level holds the FSM, shift register, byte counter and last_grant register.
- The bench instantiates the real transmitter for integration tests and a `tx_rdy` behavioural model for short-frame tests.

## Test plan
- Single request: `req`=4'b0001, msg0=24'hA55A3C, with the real transmitter → `tx_data` sequence A5, 5A, 3C; each `tx_start` one cycle after `tx_rdy` rises; `done`=4'b0001 for 1 cycle; line bits match 8N1 LSB-first.
- Round-robin fairness: `req`=4'b1111 held with re-assertion after each `done` → grant order 0, 1, 2, 3, 0, 1; no requester granted twice while another waits.
- Wrap and skip: last_grant=2, `req`=4'b0011 → requester 0 granted; then requester 1; requester 3 never granted.
- Capture isolation: change msg1 to 24'hFFFFFF one cycle after grant1 → transmitted bytes are still the values captured at grant.
- Reset mid-message: assert `rst_n`=0 during WAIT_HIGH of byte 2 → all outputs 0 next cycle, no `done`; after release with `req`=4'b0100 → requester 2 is granted within 1 cycle.
- Blocked start: hold `tx_rdy`=0 in IDLE with `req`=4'b0001 → no `tx_start` and `busy`=0; raise `tx_rdy` → `tx_start` in the next cycle.
